// File: rtl/noc_pkg.sv
// Shared NoC packet layout: default field widths, field offsets and a packed view
// of a packet, used by the local rx/tx ports and the router.
package noc_pkg;

    localparam int NOC_PAYLOAD_W = 32;
    localparam int NOC_SRC_W     = 4;
    localparam int NOC_PKT_W     = NOC_PAYLOAD_W + 1 + NOC_SRC_W;

    // Bit positions inside a packet: payload on top, flag, then source id at the bottom.
    localparam int NOC_SRC_LSB   = 0;
    localparam int NOC_FLAG_BIT  = NOC_SRC_W;
    localparam int NOC_DATA_LSB  = NOC_SRC_W + 1;

    typedef struct packed {
        logic [NOC_PAYLOAD_W-1:0] payload;
        logic                     flag;
        logic [NOC_SRC_W-1:0]     src;
    } noc_pkt_t;

endpackage

// File: rtl/noc_local_rx_port_if.sv
// Router-facing valid/ready input and core-facing head/pop/status signals of the
// local rx port; slave is the port itself, master is the router plus core side.
interface noc_local_rx_port_if
    import noc_pkg::*;
#(
    parameter int PKT_W     = NOC_PKT_W,
    parameter int PAYLOAD_W = NOC_PAYLOAD_W,
    parameter int SRC_W     = NOC_SRC_W,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                 rt_valid;
    logic                 rt_ready;
    logic [PKT_W-1:0]     rt_packet;
    logic                 cpu_valid;
    logic                 cpu_pop;
    logic [PAYLOAD_W-1:0] cpu_data;
    logic                 cpu_flag;
    logic [SRC_W-1:0]     cpu_src;
    logic [LVL_W-1:0]     cpu_level;
    logic                 cpu_irq;
    logic [CNT_W-1:0]     rx_count;

    modport slave (
        input  rt_valid, rt_packet, cpu_pop,
        output rt_ready, cpu_valid, cpu_data, cpu_flag, cpu_src, cpu_level, cpu_irq, rx_count
    );

    modport master (
        output rt_valid, rt_packet, cpu_pop,
        input  rt_ready, cpu_valid, cpu_data, cpu_flag, cpu_src, cpu_level, cpu_irq, rx_count
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; head data is combinational
// from the read pointer, level is the pointer difference (0..DEPTH).
module noc_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // NOTE: storage has no reset; an entry is only visible once the pointers cover it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/noc_local_rx_port.sv
// Receive side of a core's network interface on the router local port: buffers
// router packets, splits head fields for the core, raises a fill interrupt and counts arrivals.
module noc_local_rx_port
    import noc_pkg::*;
#(
    parameter int PAYLOAD_W  = NOC_PAYLOAD_W,
    parameter int SRC_W      = NOC_SRC_W,
    parameter int PKT_W      = NOC_PKT_W,
    parameter int DEPTH      = 4,
    parameter int IRQ_THRESH = 1,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                reset,
    noc_local_rx_port_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    if (PKT_W != PAYLOAD_W + SRC_W + 1) begin : g_bad_pkt_w
        $error("noc_local_rx_port: PKT_W must equal PAYLOAD_W+SRC_W+1");
    end
    if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_thresh
        $error("noc_local_rx_port: IRQ_THRESH must lie in 1..DEPTH");
    end

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PKT_W-1:0] head;
    logic [PKT_W-1:0] head_vis;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic             irq_q;
    logic [CNT_W-1:0] count_q;

    assign push = bus.rt_valid & ~full;
    assign pop  = bus.cpu_pop & ~empty;

    noc_sync_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.rt_packet),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Stale storage is hidden so the core sees zeros whenever nothing is queued.
    assign head_vis      = empty ? '0 : head;
    assign bus.cpu_data  = head_vis[PKT_W-1:SRC_W+1];
    assign bus.cpu_flag  = head_vis[SRC_W];
    assign bus.cpu_src   = head_vis[SRC_W-1:0];
    assign bus.rt_ready  = ~full;
    assign bus.cpu_valid = ~empty;
    assign bus.cpu_level = level;
    assign bus.cpu_irq   = irq_q;
    assign bus.rx_count  = count_q;

    // NOTE: level_next gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // irq follows the post-edge occupancy, so it changes on the same edge as the level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q   <= 1'b0;
            count_q <= '0;
        end else begin
            irq_q <= (level_next >= LVL_W'(IRQ_THRESH));
            if (push && (count_q != {CNT_W{1'b1}})) count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_local_rx_port.sv
// Directed bench for noc_local_rx_port: stimulus pushes expected packets into a
// scoreboard queue, a negedge monitor compares every head the core pops.
module tb_noc_local_rx_port;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    noc_local_rx_port_if #(.DEPTH(4), .CNT_W(16)) a_if ();
    noc_local_rx_port_if #(.DEPTH(4), .CNT_W(4))  b_if ();

    noc_local_rx_port #(.DEPTH(4), .IRQ_THRESH(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave)
    );
    noc_local_rx_port #(.DEPTH(4), .IRQ_THRESH(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [NOC_PKT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NOC_PKT_W-1:0] mk(input logic [31:0] d, input logic f, input logic [3:0] s);
        noc_pkt_t p;
        p.payload = d;
        p.flag    = f;
        p.src     = s;
        return p;
    endfunction

    // Scoreboard monitor: a pop happens at the next edge when valid and pop are both high now.
    always @(negedge clk) begin
        if (reset && a_if.cpu_valid && a_if.cpu_pop) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: got %0h expected none",
                         {a_if.cpu_data, a_if.cpu_flag, a_if.cpu_src});
            end else begin
                check("head_pkt", 64'({a_if.cpu_data, a_if.cpu_flag, a_if.cpu_src}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_idle(input string tag, input logic [15:0] cnt);
        check({tag, "_ready"}, 64'(a_if.rt_ready),  64'd1);
        check({tag, "_valid"}, 64'(a_if.cpu_valid), 64'd0);
        check({tag, "_level"}, 64'(a_if.cpu_level), 64'd0);
        check({tag, "_irq"},   64'(a_if.cpu_irq),   64'd0);
        check({tag, "_count"}, 64'(a_if.rx_count),  64'(cnt));
        check({tag, "_data"},  64'({a_if.cpu_data, a_if.cpu_flag, a_if.cpu_src}), 64'd0);
    endtask

    initial begin
        a_if.rt_valid = 1'b0; a_if.rt_packet = '0; a_if.cpu_pop = 1'b0;
        b_if.rt_valid = 1'b0; b_if.rt_packet = '0; b_if.cpu_pop = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_idle("por", 16'd0);
        reset = 1'b1;
        step();
        check_idle("por_rel", 16'd0);

        // Single packet, one-cycle show-ahead latency
        a_if.rt_valid  = 1'b1;
        a_if.rt_packet = mk(32'hDEADBEEF, 1'b1, 4'h3);
        exp_q.push_back(a_if.rt_packet);
        step();
        a_if.rt_valid = 1'b0;
        check("single_valid", 64'(a_if.cpu_valid), 64'd1);
        check("single_data",  64'(a_if.cpu_data),  64'hDEADBEEF);
        check("single_flag",  64'(a_if.cpu_flag),  64'd1);
        check("single_src",   64'(a_if.cpu_src),   64'h3);
        check("single_level", 64'(a_if.cpu_level), 64'd1);
        check("single_irq",   64'(a_if.cpu_irq),   64'd1);
        a_if.cpu_pop = 1'b1;
        step();
        a_if.cpu_pop = 1'b0;
        check_idle("single_pop", 16'd1);

        // Fill to DEPTH, stall a fifth packet, release it with one pop
        for (int k = 0; k < 4; k++) begin
            a_if.rt_valid  = 1'b1;
            a_if.rt_packet = mk(32'hA000_0000 + 32'(k), k[0], 4'(k + 8));
            exp_q.push_back(a_if.rt_packet);
            step();
        end
        check("full_ready", 64'(a_if.rt_ready),  64'd0);
        check("full_level", 64'(a_if.cpu_level), 64'd4);
        a_if.rt_packet = mk(32'hA000_0004, 1'b0, 4'hC);
        exp_q.push_back(a_if.rt_packet);
        step();
        check("stall_level", 64'(a_if.cpu_level), 64'd4);
        check("stall_count", 64'(a_if.rx_count),  64'd5);
        a_if.cpu_pop = 1'b1;
        #1;
        check("full_ready_with_pop", 64'(a_if.rt_ready), 64'd0);
        step();
        a_if.cpu_pop = 1'b0;
        check("after_pop_ready", 64'(a_if.rt_ready),  64'd1);
        check("after_pop_level", 64'(a_if.cpu_level), 64'd3);
        step();
        a_if.rt_valid = 1'b0;
        check("stall_accept_level", 64'(a_if.cpu_level), 64'd4);
        check("stall_accept_count", 64'(a_if.rx_count),  64'd6);
        a_if.cpu_pop = 1'b1;
        repeat (4) step();
        a_if.cpu_pop = 1'b0;
        check("drain_level", 64'(a_if.cpu_level), 64'd0);

        // Pops while empty are ignored
        a_if.cpu_pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0 || k == 9) check_idle("empty_pop", 16'd6);
        end
        a_if.cpu_pop = 1'b0;

        // Asynchronous reset mid-run with two entries queued and a third offered
        a_if.rt_valid  = 1'b1;
        a_if.rt_packet = mk(32'h1111_1111, 1'b1, 4'h1);
        step();
        a_if.rt_packet = mk(32'h2222_2222, 1'b0, 4'h2);
        step();
        check("pre_reset_level", 64'(a_if.cpu_level), 64'd2);
        a_if.rt_packet = mk(32'h3333_3333, 1'b1, 4'h3);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_idle("async_rst", 16'd0);
        a_if.rt_valid = 1'b0;
        step();
        check_idle("rst_held", 16'd0);
        reset = 1'b1;
        step();
        check_idle("rst_rel", 16'd0);

        // Continuous push+pop for 100 packets
        for (int i = 0; i < 100; i++) begin
            a_if.rt_valid  = 1'b1;
            a_if.cpu_pop   = 1'b1;
            a_if.rt_packet = mk(32'h1000_0000 + 32'(i), i[0], i[3:0]);
            exp_q.push_back(a_if.rt_packet);
            step();
            if (i < 3 || i == 99) check("stream_level", 64'(a_if.cpu_level), 64'd1);
        end
        a_if.rt_valid = 1'b0;
        step();
        a_if.cpu_pop = 1'b0;
        check("stream_count", 64'(a_if.rx_count),  64'd100);
        check("stream_level_end", 64'(a_if.cpu_level), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Counter saturation on the CNT_W=4 instance
        for (int i = 0; i < 20; i++) begin
            b_if.rt_valid  = 1'b1;
            b_if.cpu_pop   = 1'b1;
            b_if.rt_packet = mk(32'hB000_0000 + 32'(i), 1'b0, i[3:0]);
            step();
            if (i == 13) check("sat_count_14", 64'(b_if.rx_count), 64'd14);
            if (i == 14) check("sat_count_15", 64'(b_if.rx_count), 64'd15);
        end
        b_if.rt_valid = 1'b0;
        b_if.cpu_pop  = 1'b0;
        check("sat_count_20", 64'(b_if.rx_count),  64'd15);
        check("sat_level",    64'(b_if.cpu_level), 64'd1);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
